// File: rtl/pwd_pkg.sv
// Shared types and default sizing for the keypad password entry controller.
package pwd_pkg;

    localparam int DEF_DIGIT_W        = 4;
    localparam int DEF_PWD_LEN        = 4;
    localparam int DEF_OPEN_CYCLES    = 8;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        OPEN,
        LOCKED
    } state_t;

endpackage

// File: rtl/pwd_digit_buffer.sv
// Digit capture shift register with a captured-digit counter and an overflow flag.
module pwd_digit_buffer
    import pwd_pkg::*;
#(
    parameter int DIGIT_W = DEF_DIGIT_W,
    parameter int PWD_LEN = DEF_PWD_LEN
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           shift,
    input  logic [DIGIT_W-1:0]             digit_in,
    output logic [PWD_LEN*DIGIT_W-1:0]     buf_out,
    output logic [$clog2(PWD_LEN+1)-1:0]   cnt_out,
    output logic                           overflow_out
);

    localparam int BUF_W = PWD_LEN * DIGIT_W;
    localparam int CNT_W = $clog2(PWD_LEN + 1);

    logic [BUF_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // A full buffer keeps its contents; extra digits only poison the entry.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear) begin
            shreg_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (shift) begin
            if (cnt_q < CNT_W'(PWD_LEN)) begin
                shreg_d = (shreg_q << DIGIT_W) | BUF_W'(digit_in);
                cnt_d   = cnt_q + CNT_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign buf_out      = shreg_q;
    assign cnt_out      = cnt_q;
    assign overflow_out = ovf_q;

endmodule

// File: rtl/pwd_entry_ctrl.sv
// Keypad password entry controller: collects digits, checks them on Enter,
// pulses unlock or fail_pulse, and stays inert while the attempt counter locks it out.
module pwd_entry_ctrl
    import pwd_pkg::*;
#(
    parameter int DIGIT_W        = DEF_DIGIT_W,
    parameter int PWD_LEN        = DEF_PWD_LEN,
    parameter int OPEN_CYCLES    = DEF_OPEN_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           key_valid,
    input  logic [DIGIT_W-1:0]             key_digit,
    input  logic                           key_enter,
    input  logic                           key_clear,
    input  logic [PWD_LEN*DIGIT_W-1:0]     pwd_stored,
    input  logic                           admin_lock,
    output logic                           unlock,
    output logic                           fail_pulse,
    output logic                           locked,
    output logic [$clog2(PWD_LEN+1)-1:0]   digit_cnt,
    output logic                           busy
);

    localparam int BUF_W  = PWD_LEN * DIGIT_W;
    localparam int CNT_W  = $clog2(PWD_LEN + 1);
    localparam int OPEN_W = $clog2(OPEN_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state_q, state_d;
    logic [OPEN_W-1:0] open_tmr_q, open_tmr_d;
    logic [TO_W-1:0]   idle_tmr_q, idle_tmr_d;
    logic              unlock_q, unlock_d;
    logic              fail_q, fail_d;
    logic              buf_clear, buf_shift;
    logic [BUF_W-1:0]  entry_buf;
    logic              entry_ovf;
    logic              match;

    pwd_digit_buffer #(
        .DIGIT_W (DIGIT_W),
        .PWD_LEN (PWD_LEN)
    ) u_buffer (
        .clk          (clk),
        .rst          (rst),
        .clear        (buf_clear),
        .shift        (buf_shift),
        .digit_in     (key_digit),
        .buf_out      (entry_buf),
        .cnt_out      (digit_cnt),
        .overflow_out (entry_ovf)
    );

    assign match = (digit_cnt == CNT_W'(PWD_LEN)) && !entry_ovf && (entry_buf == pwd_stored);

    always_comb begin
        state_d    = state_q;
        open_tmr_d = open_tmr_q;
        idle_tmr_d = idle_tmr_q;
        unlock_d   = 1'b0;
        fail_d     = 1'b0;
        buf_clear  = 1'b0;
        buf_shift  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (admin_lock) begin
                    state_d   = LOCKED;
                    buf_clear = 1'b1;
                end else if (!key_clear && (key_valid || key_enter)) begin
                    buf_shift  = key_valid;
                    idle_tmr_d = TO_W'(TIMEOUT_CYCLES - 1);
                    state_d    = key_enter ? CHECK : ENTRY;
                end
            end
            ENTRY: begin
                if (admin_lock) begin
                    state_d   = LOCKED;
                    buf_clear = 1'b1;
                end else if (key_clear) begin
                    state_d   = IDLE;
                    buf_clear = 1'b1;
                end else if (key_valid || key_enter) begin
                    buf_shift  = key_valid;
                    idle_tmr_d = TO_W'(TIMEOUT_CYCLES - 1);
                    if (key_enter) begin
                        state_d = CHECK;
                    end
                end else if (idle_tmr_q == '0) begin
                    state_d   = IDLE;
                    buf_clear = 1'b1;
                end else begin
                    idle_tmr_d = idle_tmr_q - TO_W'(1);
                end
            end
            // A lockout arriving during the compare still reports a wrong code.
            CHECK: begin
                buf_clear = 1'b1;
                if (admin_lock) begin
                    state_d = LOCKED;
                    fail_d  = !match;
                end else if (match) begin
                    state_d    = OPEN;
                    unlock_d   = 1'b1;
                    open_tmr_d = OPEN_W'(OPEN_CYCLES - 1);
                end else begin
                    state_d = IDLE;
                    fail_d  = 1'b1;
                end
            end
            OPEN: begin
                if (admin_lock) begin
                    state_d   = LOCKED;
                    buf_clear = 1'b1;
                end else if (open_tmr_q == '0) begin
                    state_d = IDLE;
                end else begin
                    unlock_d   = 1'b1;
                    open_tmr_d = open_tmr_q - OPEN_W'(1);
                end
            end
            LOCKED: begin
                buf_clear = 1'b1;
                if (!admin_lock) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                buf_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            open_tmr_q <= '0;
            idle_tmr_q <= '0;
            unlock_q   <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            open_tmr_q <= open_tmr_d;
            idle_tmr_q <= idle_tmr_d;
            unlock_q   <= unlock_d;
            fail_q     <= fail_d;
        end
    end

    assign unlock     = unlock_q;
    assign fail_pulse = fail_q;
    assign locked     = (state_q == LOCKED);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_pwd_entry_ctrl.sv
// Scoreboard bench for pwd_entry_ctrl: stimulus predicts unlock/fail events from
// the typed key sequence, and a negedge monitor matches them against the DUT.
module tb_pwd_entry_ctrl;

    localparam int DIGIT_W        = 4;
    localparam int PWD_LEN        = 4;
    localparam int OPEN_CYCLES    = 8;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int EV_OPEN        = 0;
    localparam int EV_FAIL        = 1;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic                         clk;
    logic                         rst;
    logic                         key_valid;
    logic [DIGIT_W-1:0]           key_digit;
    logic                         key_enter;
    logic                         key_clear;
    logic [PWD_LEN*DIGIT_W-1:0]   pwd_stored;
    logic                         admin_lock;
    logic                         unlock;
    logic                         fail_pulse;
    logic                         locked;
    logic [$clog2(PWD_LEN+1)-1:0] digit_cnt;
    logic                         busy;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  exp_q[$];
    logic [DIGIT_W-1:0] model_keys[$];
    bit   model_locked = 1'b0;
    int   idle_run = 0;
    bit   force_lock = 1'b0;
    bit   att_en = 1'b0;
    bit   att_clr = 1'b0;
    int   att_cnt = 0;
    bit   prev_unlock = 1'b0;
    bit   prev_fail = 1'b0;
    int   width = 0;

    pwd_entry_ctrl #(
        .DIGIT_W        (DIGIT_W),
        .PWD_LEN        (PWD_LEN),
        .OPEN_CYCLES    (OPEN_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .key_enter  (key_enter),
        .key_clear  (key_clear),
        .pwd_stored (pwd_stored),
        .admin_lock (admin_lock),
        .unlock     (unlock),
        .fail_pulse (fail_pulse),
        .locked     (locked),
        .digit_cnt  (digit_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Stand-in for the failed-attempt counter: three pulses raise admin_lock.
    always @(negedge clk) begin
        if (att_clr) att_cnt = 0;
        else if (att_en && fail_pulse) att_cnt++;
    end
    assign admin_lock = force_lock || (att_cnt >= 3);

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic bit isMatch(input logic [PWD_LEN*DIGIT_W-1:0] pwd);
        if (model_keys.size() != PWD_LEN) return 1'b0;
        for (int i = 0; i < PWD_LEN; i++) begin
            if (model_keys[i] != pwd[(PWD_LEN-1-i)*DIGIT_W +: DIGIT_W]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic popEvent(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            checkOutput("event_kind", kind, e.kind);
            checkOutput("event_cycle", cyc, e.cyc);
        end
    endtask

    // Monitor: every unlock rise or fail pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (rst) begin
            prev_unlock = 1'b0;
            prev_fail   = 1'b0;
            width       = 0;
        end else begin
            if (fail_pulse) begin
                checkOutput("fail_back_to_back", int'(prev_fail), 0);
                popEvent(EV_FAIL);
            end
            if (unlock && !prev_unlock) begin
                popEvent(EV_OPEN);
                width = 0;
            end
            if (unlock) width++;
            if (!unlock && prev_unlock) checkOutput("unlock_width", width, OPEN_CYCLES);
            prev_unlock = unlock;
            prev_fail   = fail_pulse;
        end
    end

    // One clock of stimulus; the model predicts what an Enter here should produce.
    task automatic applyStimulus(input bit v, input logic [DIGIT_W-1:0] d, input bit e, input bit c);
        key_valid = v;
        key_digit = d;
        key_enter = e;
        key_clear = c;
        if (v || e) idle_run = 0;
        else idle_run++;
        if (!model_locked) begin
            if (c) begin
                model_keys.delete();
            end else begin
                if (v) model_keys.push_back(d);
                if (e) begin
                    exp_q.push_back('{isMatch(pwd_stored) ? EV_OPEN : EV_FAIL, cyc + 2});
                    model_keys.delete();
                end else if (idle_run >= TIMEOUT_CYCLES) begin
                    model_keys.delete();
                end
            end
        end
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_digit = '0;
        key_enter = 1'b0;
        key_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic typeDigit(input int d);
        applyStimulus(1'b1, DIGIT_W'(d), 1'b0, 1'b0);
    endtask

    task automatic pressEnter();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic typeSeq(input int n, input bit use_pwd, input bit merge_enter);
        logic [DIGIT_W-1:0] d;
        for (int i = 0; i < n; i++) begin
            if (use_pwd && i < PWD_LEN) d = pwd_stored[(PWD_LEN-1-i)*DIGIT_W +: DIGIT_W];
            else d = DIGIT_W'($urandom_range(0, 15));
            if (i == n - 1) begin
                applyStimulus(1'b1, d, merge_enter, 1'b0);
            end else begin
                applyStimulus(1'b1, d, 1'b0, 1'b0);
                idle($urandom_range(0, 4));
            end
        end
    endtask

    task automatic type1234();
        typeDigit(1); typeDigit(2); typeDigit(3); typeDigit(4);
    endtask

    task automatic type1235();
        typeDigit(1); typeDigit(2); typeDigit(3); typeDigit(5);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int kind;
        int n;
        bit merge;
        rst        = 1'b1;
        key_valid  = 1'b0;
        key_digit  = '0;
        key_enter  = 1'b0;
        key_clear  = 1'b0;
        pwd_stored = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_unlock", int'(unlock), 0);
        rst = 1'b0;
        checkOutput("reset_fail", int'(fail_pulse), 0);
        checkOutput("reset_locked", int'(locked), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_digit_cnt", int'(digit_cnt), 0);

        type1234();
        checkOutput("cnt_after_4", int'(digit_cnt), 4);
        pressEnter();
        idle(OPEN_CYCLES + 3);

        type1235(); pressEnter(); idle(3);
        typeDigit(1); typeDigit(2); typeDigit(3); pressEnter(); idle(3);
        type1234(); typeDigit(4);
        checkOutput("cnt_overflow_sat", int'(digit_cnt), 4);
        pressEnter(); idle(3);
        pressEnter(); idle(3);

        typeDigit(1); typeDigit(2);
        checkOutput("cnt_before_clear", int'(digit_cnt), 2);
        checkOutput("busy_in_entry", int'(busy), 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("cnt_after_clear", int'(digit_cnt), 0);
        checkOutput("busy_after_clear", int'(busy), 0);

        typeDigit(1); typeDigit(2);
        idle(TIMEOUT_CYCLES - 1);
        checkOutput("busy_before_timeout", int'(busy), 1);
        idle(1);
        checkOutput("busy_after_timeout", int'(busy), 0);
        checkOutput("cnt_after_timeout", int'(digit_cnt), 0);

        typeDigit(1); typeDigit(2); typeDigit(3);
        applyStimulus(1'b1, 4'd4, 1'b1, 1'b0);
        idle(OPEN_CYCLES + 3);

        typeDigit(1); typeDigit(2);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("busy_clear_enter", int'(busy), 0);
        checkOutput("cnt_clear_enter", int'(digit_cnt), 0);
        idle(3);

        att_en = 1'b1;
        repeat (3) begin
            type1235(); pressEnter(); idle(3);
        end
        checkOutput("locked_after_3_fails", int'(locked), 1);
        checkOutput("busy_when_locked", int'(busy), 1);
        model_locked = 1'b1;
        model_keys.delete();
        typeDigit(1); typeDigit(2); typeDigit(3);
        checkOutput("cnt_ignored_locked", int'(digit_cnt), 0);
        typeDigit(4); pressEnter(); idle(OPEN_CYCLES + 3);
        checkOutput("unlock_while_locked", int'(unlock), 0);
        att_en  = 1'b0;
        att_clr = 1'b1;
        idle(2);
        att_clr = 1'b0;
        model_locked = 1'b0;
        checkOutput("locked_released", int'(locked), 0);
        checkOutput("busy_released", int'(busy), 0);
        type1234(); pressEnter(); idle(OPEN_CYCLES + 3);

        type1234(); pressEnter();
        idle(3);
        checkOutput("unlock_3rd_open_cycle", int'(unlock), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("unlock_async_reset", int'(unlock), 0);
        checkOutput("busy_async_reset", int'(busy), 0);
        model_keys.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        type1235(); pressEnter();
        force_lock = 1'b1;
        idle(1);
        checkOutput("locked_after_check", int'(locked), 1);
        idle(2);
        force_lock = 1'b0;
        idle(1);
        checkOutput("busy_after_unlock_release", int'(busy), 0);

        for (int t = 0; t < 40; t++) begin
            pwd_stored = 16'($urandom);
            kind = $urandom_range(0, 4);
            if (kind <= 2) begin
                if ($urandom_range(0, 1) == 1) begin
                    n = PWD_LEN;
                    merge = ($urandom_range(0, 3) == 0);
                    typeSeq(n, 1'b1, merge);
                end else begin
                    n = $urandom_range(0, 6);
                    merge = (n > 0) && ($urandom_range(0, 3) == 0);
                    typeSeq(n, 1'b0, merge);
                end
                if (!merge) begin
                    idle($urandom_range(0, 3));
                    pressEnter();
                end
                idle(1);
                pwd_stored = 16'($urandom);
                idle(OPEN_CYCLES + 2);
            end else if (kind == 3) begin
                n = $urandom_range(1, 5);
                typeSeq(n, 1'b0, 1'b0);
                checkOutput("rand_cnt_before_clear", int'(digit_cnt), (n < PWD_LEN) ? n : PWD_LEN);
                applyStimulus(1'b0, '0, 1'($urandom_range(0, 1)), 1'b1);
                checkOutput("rand_cnt_after_clear", int'(digit_cnt), 0);
                checkOutput("rand_busy_after_clear", int'(busy), 0);
                idle(2);
            end else begin
                n = $urandom_range(1, 3);
                typeSeq(n, 1'b0, 1'b0);
                idle(TIMEOUT_CYCLES - 1);
                checkOutput("rand_busy_pre_timeout", int'(busy), 1);
                idle(1);
                checkOutput("rand_busy_timeout", int'(busy), 0);
                checkOutput("rand_cnt_timeout", int'(digit_cnt), 0);
            end
        end

        idle(20);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwd_entry_ctrl.md
Name: pwd_entry_ctrl

Overview:
Keypad-side password entry controller for the door-security subsystem. It collects digit keystrokes, compares them against the stored password when Enter is pressed, and drives unlock on a match. On a mismatch it emits a one-cycle fail_pulse, which feeds the failed-attempt counter's enable. It also consumes that counter's admin_lock output and refuses all entry while the lock is active.

Parameters:
DIGIT_W, 4, bit width of one keypad digit
PWD_LEN, 4, number of digits in a password
OPEN_CYCLES, 8, cycles unlock stays high after a match (>=1)
TIMEOUT_CYCLES, 16, idle cycles in ENTRY before the entry is discarded (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
key_valid  in  1  one-cycle strobe: key_digit is valid
key_digit  in  DIGIT_W  digit value
key_enter  in  1  one-cycle strobe: submit the entry
key_clear  in  1  one-cycle strobe: abandon the entry
pwd_stored  in  PWD_LEN*DIGIT_W  reference password; first digit in the MS digit slot
admin_lock  in  1  level from the attempt counter; 1 = locked out
unlock  out  1  door release, registered
fail_pulse  out  1  registered, exactly 1 cycle per failed attempt
locked  out  1  high while state==LOCKED
digit_cnt  out  clog2(PWD_LEN+1)  digits captured so far
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async): state IDLE; buffer, digit_cnt, overflow flag, timers and all outputs are 0.
- States: IDLE, ENTRY, CHECK, OPEN, LOCKED.
- Priority in every state: admin_lock, then key_clear, then key_valid/key_enter.
- IDLE:
  - key_valid: digit shifted in, digit_cnt=1, go to ENTRY.
  - key_enter: go to CHECK with digit_cnt=0.
  - key_clear: no effect.
- ENTRY:
  - key_valid with digit_cnt<PWD_LEN: shift digit in at the LS slot, digit_cnt+1, timeout reloaded.
  - key_valid with digit_cnt==PWD_LEN: digit discarded, overflow flag set, timeout reloaded.
  - key_valid and key_enter in the same cycle: the digit is captured first, then the state goes to CHECK.
  - key_clear: buffer, digit_cnt and overflow cleared; go to IDLE; no fail_pulse.
  - Timeout (TIMEOUT_CYCLES cycles with no key_valid or key_enter): same as key_clear.
- CHECK (exactly 1 cycle; keys ignored):
  - match = (digit_cnt==PWD_LEN) & !overflow & (buffer==pwd_stored).
  - On match: load the open timer, go to OPEN.
  - Otherwise: fail_pulse<=1, so it is high in the following cycle; go to IDLE.
  - Buffer, digit_cnt and overflow are cleared on exit in both cases.
- OPEN: unlock=1 for exactly OPEN_CYCLES cycles, then unlock=0 and go to IDLE. Keys are ignored.
- admin_lock=1 in any state: go to LOCKED next cycle; unlock<=0; buffer cleared.
  - Exception in CHECK: a mismatch still produces fail_pulse, but a match does not open.
- LOCKED: locked=1, all keys ignored. When admin_lock returns to 0, go to IDLE.
- fail_pulse is never high for two consecutive cycles. Latency from key_enter to unlock or fail_pulse is 2 cycles.
- pwd_stored is sampled only in CHECK; changes at other times have no effect.
- rst asserted mid-OPEN drops unlock asynchronously.

Decomposition:
- Package pwd_pkg: state enum (IDLE, ENTRY, CHECK, OPEN, LOCKED); defaults DIGIT_W, PWD_LEN, OPEN_CYCLES, TIMEOUT_CYCLES.
- Sub-module pwd_digit_buffer: shift register, digit counter and overflow flag, with clear/shift controls.
- Parent pwd_entry_ctrl: FSM, comparator, open and timeout timers.

Test Plan:
- pwd_stored=16'h1234. Keys 1,2,3,4 then Enter -> unlock high 8 cycles starting 2 cycles after Enter; fail_pulse stays 0.
- Keys 1,2,3,5 then Enter -> fail_pulse high exactly 1 cycle, unlock 0. Keys 1,2,3 then Enter -> fail_pulse. Keys 1,2,3,4,4 then Enter -> fail_pulse (overflow). Enter in IDLE -> fail_pulse.
- fail_pulse looped to the attempt counter's en, three wrong entries -> admin_lock=1 after the third pulse, locked=1. Correct 1,2,3,4 then Enter -> unlock stays 0 and no fail_pulse. Counter reset -> IDLE, and a correct entry then opens.
- Keys 1,2 then key_clear -> digit_cnt=0, IDLE, no fail_pulse. Keys 1,2 then 16 idle cycles -> IDLE, digit_cnt=0, no fail_pulse.
- Digit 4 and Enter in the same cycle after 1,2,3 -> unlock. key_clear with Enter in the same cycle -> IDLE, no check.
- rst asserted on the 3rd OPEN cycle -> unlock=0 immediately and state IDLE. admin_lock rising during CHECK with a wrong code -> fail_pulse issued and then LOCKED.
